// File: rtl/pixel_sensor_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_sensor_ctrl_pkg
// Brief    : Shared configuration for the pixel sensor controller: widths,
//            default phase lengths and the controller state encoding.
// Revision : 1.0
// ============================================================================
package pixel_sensor_ctrl_pkg;

    localparam int PIXEL_BITS = 8;
    localparam int C_ERASE    = 5;
    localparam int C_EXPOSE   = 255;
    localparam int C_CONVERT  = 255;
    localparam int C_READ     = 5;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ERASE   = 4'd1,
        ST_GAP_E   = 4'd2,
        ST_EXPOSE  = 4'd3,
        ST_GAP_X   = 4'd4,
        ST_CONVERT = 4'd5,
        ST_GAP_C   = 4'd6,
        ST_READ    = 4'd7,
        ST_GAP_R   = 4'd8
    } ctrl_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_sensor_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_sensor_ctrl_if
// Brief    : Valid/ready port carrying captured pixel values downstream.
// Revision : 1.0
// ============================================================================
interface pixel_sensor_ctrl_if #(
    parameter int PIXEL_BITS = pixel_sensor_ctrl_pkg::PIXEL_BITS
);
    logic [PIXEL_BITS-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/pixel_sensor_ctrl_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_sensor_ctrl_phase_timer
// Brief    : Loadable down-counter; last is high in the final cycle of a phase.
// Revision : 1.0
// ============================================================================
module pixel_sensor_ctrl_phase_timer #(
    parameter int WIDTH = 9
) (
    input  wire             clk,
    input  wire             reset,
    input  wire             load,
    input  wire [WIDTH-1:0] len,
    output logic            last
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Loading len-1 makes a phase of length len end when the count hits zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= len - C_ONE;
        end else if (r_count != '0) begin
            r_count <= r_count - C_ONE;
        end
    end

    assign last = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pixel_sensor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pixel_sensor_ctrl
// Brief    : Sequences erase/expose/convert/read for the pixel, drives the
//            ramp code and captures pixel data onto a valid/ready port.
// Revision : 1.0
// ============================================================================
module pixel_sensor_ctrl
    import pixel_sensor_ctrl_pkg::*;
#(
    parameter int PIXEL_BITS = pixel_sensor_ctrl_pkg::PIXEL_BITS,
    parameter int C_ERASE    = pixel_sensor_ctrl_pkg::C_ERASE,
    parameter int C_EXPOSE   = pixel_sensor_ctrl_pkg::C_EXPOSE,
    parameter int C_CONVERT  = pixel_sensor_ctrl_pkg::C_CONVERT,
    parameter int C_READ     = pixel_sensor_ctrl_pkg::C_READ
) (
    input  wire                   clk,
    input  wire                   reset,
    input  wire                   start,
    input  wire                   continuous,
    output logic                  erase,
    output logic                  expose,
    output logic                  convert,
    output logic                  read,
    output logic [PIXEL_BITS-1:0] pixel_counter,
    input  wire  [PIXEL_BITS-1:0] pix_data,
    pixel_sensor_ctrl_if.master   out_if,
    output logic                  busy,
    output logic                  overrun
);

    localparam int C_TW = $clog2(max4(C_ERASE, C_EXPOSE, C_CONVERT, C_READ)) + 1;
    localparam logic [C_TW-1:0] C_LEN_ERASE   = C_TW'(C_ERASE);
    localparam logic [C_TW-1:0] C_LEN_EXPOSE  = C_TW'(C_EXPOSE);
    localparam logic [C_TW-1:0] C_LEN_CONVERT = C_TW'(C_CONVERT);
    localparam logic [C_TW-1:0] C_LEN_READ    = C_TW'(C_READ);
    localparam logic [PIXEL_BITS-1:0] C_CNT_MAX = '1;
    localparam logic [PIXEL_BITS-1:0] C_CNT_ONE = PIXEL_BITS'(1);

    ctrl_state_t     r_state;
    ctrl_state_t     w_next;
    logic            w_load;
    logic [C_TW-1:0] w_len;
    logic            w_last;
    logic            w_capture;

    pixel_sensor_ctrl_phase_timer #(.WIDTH(C_TW)) u_phase_timer (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .len   (w_len),
        .last  (w_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every phase is entered from IDLE or a gap, so the timer is loaded there.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_len  = C_LEN_ERASE;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_ERASE;
                    w_load = 1'b1;
                    w_len  = C_LEN_ERASE;
                end
            end
            ST_ERASE:   if (w_last) w_next = ST_GAP_E;
            ST_GAP_E: begin
                w_next = ST_EXPOSE;
                w_load = 1'b1;
                w_len  = C_LEN_EXPOSE;
            end
            ST_EXPOSE:  if (w_last) w_next = ST_GAP_X;
            ST_GAP_X: begin
                w_next = ST_CONVERT;
                w_load = 1'b1;
                w_len  = C_LEN_CONVERT;
            end
            ST_CONVERT: if (w_last) w_next = ST_GAP_C;
            ST_GAP_C: begin
                w_next = ST_READ;
                w_load = 1'b1;
                w_len  = C_LEN_READ;
            end
            ST_READ:    if (w_last) w_next = ST_GAP_R;
            ST_GAP_R: begin
                if (continuous) begin
                    w_next = ST_ERASE;
                    w_load = 1'b1;
                    w_len  = C_LEN_ERASE;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default:    w_next = ST_IDLE;
        endcase
    end

    assign w_capture = (r_state == ST_READ) && w_last;
    assign busy      = (r_state != ST_IDLE);

    // Controls decode the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            erase         <= 1'b0;
            expose        <= 1'b0;
            convert       <= 1'b0;
            read          <= 1'b0;
            pixel_counter <= '0;
        end else begin
            erase   <= (w_next == ST_ERASE);
            expose  <= (w_next == ST_EXPOSE);
            convert <= (w_next == ST_CONVERT);
            read    <= (w_next == ST_READ);
            if ((r_state == ST_CONVERT) && (w_next == ST_CONVERT)) begin
                if (pixel_counter != C_CNT_MAX) begin
                    pixel_counter <= pixel_counter + C_CNT_ONE;
                end
            end else begin
                pixel_counter <= '0;
            end
        end
    end

    // A fresh capture takes priority over a simultaneous downstream accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_if.out_data  <= '0;
            out_if.out_valid <= 1'b0;
            overrun          <= 1'b0;
        end else if (w_capture) begin
            out_if.out_data  <= pix_data;
            out_if.out_valid <= 1'b1;
            if (out_if.out_valid && !out_if.out_ready) begin
                overrun <= 1'b1;
            end
        end else if (out_if.out_valid && out_if.out_ready) begin
            out_if.out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_sensor_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pixel_sensor_ctrl
// Brief    : Self-checking bench for pixel_sensor_ctrl with a capture scoreboard.
// Revision : 1.0
// ============================================================================
module tb_pixel_sensor_ctrl;

    localparam int PB    = 8;
    localparam int C_E   = 5;
    localparam int C_X   = 255;
    localparam int C_C   = 255;
    localparam int C_R   = 5;
    localparam int FRAME = C_E + C_X + C_C + C_R + 4;
    localparam int C_C2  = 300;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic [PB-1:0] pix_data = '0;
    logic          erase, expose, convert, read, busy, overrun;
    logic [PB-1:0] pixel_counter;

    logic          start2 = 1'b0;
    logic          erase2, expose2, convert2, read2, busy2, overrun2;
    logic [PB-1:0] pixel_counter2;
    logic [PB-1:0] pix_data2 = '0;

    pixel_sensor_ctrl_if #(.PIXEL_BITS(PB)) out_if ();
    pixel_sensor_ctrl_if #(.PIXEL_BITS(PB)) out_if2 ();

    pixel_sensor_ctrl #(
        .PIXEL_BITS(PB), .C_ERASE(C_E), .C_EXPOSE(C_X), .C_CONVERT(C_C), .C_READ(C_R)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .erase(erase), .expose(expose), .convert(convert), .read(read),
        .pixel_counter(pixel_counter), .pix_data(pix_data), .out_if(out_if),
        .busy(busy), .overrun(overrun)
    );

    pixel_sensor_ctrl #(
        .PIXEL_BITS(PB), .C_ERASE(2), .C_EXPOSE(3), .C_CONVERT(C_C2), .C_READ(2)
    ) dut_sat (
        .clk(clk), .reset(reset), .start(start2), .continuous(1'b0),
        .erase(erase2), .expose(expose2), .convert(convert2), .read(read2),
        .pixel_counter(pixel_counter2), .pix_data(pix_data2), .out_if(out_if2),
        .busy(busy2), .overrun(overrun2)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_accepts = 0;
    longint        cycle = 0;
    logic [PB-1:0] exp_q[$];
    longint        rise_q[$];
    logic          prev_erase = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted output must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && out_if.out_valid && out_if.out_ready) begin
            n_accepts++;
            if (exp_q.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
            else chk("out_data", 64'(out_if.out_data), 64'(exp_q.pop_front()));
        end
        if (erase && !prev_erase) rise_q.push_back(cycle);
        prev_erase = erase;
    end

    function automatic int sat(input int k);
        return (k > 255) ? 255 : k;
    endfunction

    task automatic phase(input string name, input int len, input logic [3:0] ctrl,
                         input bit ramp, input bit poke);
        int bad = 0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if ({erase, expose, convert, read} !== ctrl) bad++;
            if (busy !== 1'b1) bad++;
            if (ramp) begin
                if (pixel_counter !== PB'(sat(k))) bad++;
            end else if (pixel_counter !== '0) begin
                bad++;
            end
            if (poke) start = (k == 10);
        end
        chk(name, 64'(bad), 64'd0);
    endtask

    // Entered so that the next negedge falls in the first ERASE cycle.
    task automatic run_frame(input logic [PB-1:0] pix, input bit push, input bit poke);
        phase("erase",   C_E, 4'b1000, 1'b0, 1'b0);
        phase("gap_e",   1,   4'b0000, 1'b0, 1'b0);
        phase("expose",  C_X, 4'b0100, 1'b0, 1'b0);
        phase("gap_x",   1,   4'b0000, 1'b0, 1'b0);
        phase("convert", C_C, 4'b0010, 1'b1, poke);
        phase("gap_c",   1,   4'b0000, 1'b0, 1'b0);
        pix_data = pix;
        if (push) exp_q.push_back(pix);
        phase("read",    C_R, 4'b0001, 1'b0, 1'b0);
        phase("gap_r",   1,   4'b0000, 1'b0, 1'b0);
        chk("valid_at_read_fall", 64'(out_if.out_valid), 64'd1);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        chk(name, 64'({erase, expose, convert, read, busy, pixel_counter}), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int acc0;
        int bad;
        int w;
        int bad_ramp;
        int bad_sat;
        out_if.out_ready  = 1'b1;
        out_if2.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({erase, expose, convert, read, busy, overrun,
                                  out_if.out_valid, out_if.out_data, pixel_counter}), 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        check_idle("idle_after_reset");

        // Reset in the middle of EXPOSE.
        pulse_start();
        repeat (99) @(posedge clk);
        #2 chk("expose_before_reset", 64'(expose), 64'd1);
        reset = 1'b0;
        #1 chk("async_reset_outputs", 64'({erase, expose, convert, read, busy, overrun,
                                           out_if.out_valid, out_if.out_data, pixel_counter}), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Single frame after reset: erase must follow start by one cycle.
        pulse_start();
        run_frame(8'hA5, 1'b1, 1'b0);
        chk("single_out_data", 64'(out_if.out_data), 64'hA5);
        check_idle("idle_after_single");

        // Continuous frames with an always-ready sink.
        rise_q.delete();
        acc0 = n_accepts;
        continuous = 1'b1;
        pulse_start();
        run_frame(8'h10, 1'b1, 1'b0);
        run_frame(8'h11, 1'b1, 1'b0);
        @(posedge clk); #1 continuous = 1'b0;
        run_frame(8'h12, 1'b1, 1'b0);
        check_idle("idle_after_continuous");
        chk("erase_rise_count", 64'(rise_q.size()), 64'd3);
        if (rise_q.size() == 3) begin
            chk("frame_period_1", 64'(rise_q[1] - rise_q[0]), 64'(FRAME));
            chk("frame_period_2", 64'(rise_q[2] - rise_q[1]), 64'(FRAME));
        end
        chk("continuous_accepts", 64'(n_accepts - acc0), 64'd3);
        chk("overrun_clean", 64'(overrun), 64'd0);

        // Stalled sink across two frames.
        out_if.out_ready = 1'b0;
        continuous = 1'b1;
        pulse_start();
        run_frame(8'h11, 1'b0, 1'b0);
        @(posedge clk); #1 continuous = 1'b0;
        run_frame(8'h5A, 1'b1, 1'b0);
        chk("overrun_set", 64'(overrun), 64'd1);
        chk("overwritten_data", 64'(out_if.out_data), 64'h5A);
        @(posedge clk); #1 out_if.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("valid_cleared", 64'(out_if.out_valid), 64'd0);
        chk("overrun_sticky", 64'(overrun), 64'd1);

        // start pulsed during CONVERT is ignored.
        pulse_start();
        run_frame(8'h3C, 1'b1, 1'b1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || erase !== 1'b0) bad++;
        end
        chk("no_extra_frame", 64'(bad), 64'd0);

        // Saturating ramp with a convert phase longer than the code range.
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        w = 0;
        @(negedge clk);
        while (convert2 !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("sat_reach_convert", 64'(convert2), 64'd1);
        bad_ramp = 0;
        bad_sat  = 0;
        for (int k = 0; k < C_C2; k++) begin
            if (k > 0) @(negedge clk);
            if (convert2 !== 1'b1) bad_ramp++;
            if (k < 255) begin
                if (pixel_counter2 !== PB'(k)) bad_ramp++;
            end else if (pixel_counter2 !== 8'hFF) begin
                bad_sat++;
            end
        end
        chk("sat_ramp", 64'(bad_ramp), 64'd0);
        chk("sat_hold", 64'(bad_sat), 64'd0);
        @(negedge clk);
        chk("sat_leave_convert", 64'({convert2, pixel_counter2}), 64'd0);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_sensor_ctrl.md
Name: pixel_sensor_ctrl

Overview:
- Synthesizable replacement for the behavioural control loop that drives PIXEL_SENSOR.
- Sequences erase, expose, convert and read phases.
- Generates the digital ramp code (pixel_counter) during convert.
- Captures pix_data at the end of read and presents it on a valid/ready output port to the downstream readout/frame buffer.
- Sits directly upstream of PIXEL_SENSOR (control and ramp) and directly downstream of it (data capture).

Parameters:
- PIXEL_BITS, 8, width of ramp code and pixel data (from PixelSensorConfig)
- C_ERASE, 5, erase phase length in clk cycles (>=1)
- C_EXPOSE, 255, expose phase length in clk cycles (>=1)
- C_CONVERT, 255, convert phase length in clk cycles (>=1)
- C_READ, 5, read phase length in clk cycles (>=1)

Ports:
- clk  in  1  single system clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request one frame; sampled in IDLE only
- continuous  in  1  when high at end of READ, next frame starts without start
- erase  out  1  pixel erase control
- expose  out  1  pixel expose control; also gates anaBias1 at top level
- convert  out  1  convert phase flag; also gates anaRamp at top level
- read  out  1  pixel read enable; pixel drives pix_data while high
- pixel_counter  out  PIXEL_BITS  digital ramp code to pixel
- pix_data  in  PIXEL_BITS  pixel data bus, valid during read
- out_data  out  PIXEL_BITS  captured pixel value
- out_valid  out  1  out_data valid; held until accepted
- out_ready  in  1  downstream accept
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky: a capture overwrote unaccepted data

Behaviour:
- Reset (async assert, low):
  - State IDLE.
  - All outputs 0, including out_data, overrun and pixel_counter.
  - Phase timer cleared.
- States: IDLE, ERASE, GAP_E, EXPOSE, GAP_X, CONVERT, GAP_C, READ, GAP_R.
- All control outputs are registered; exactly one of erase/expose/convert/read is high in its own state; all are low in IDLE and GAP_*.
- IDLE: start high at a posedge -> ERASE; erase rises on that edge (1-cycle latency from start sampled).
- Each phase state X holds for exactly C_X cycles, then moves to its GAP state for 1 cycle (break-before-make).
- Gap transitions:
  - GAP_E -> EXPOSE.
  - GAP_X -> CONVERT.
  - GAP_C -> READ.
  - GAP_R -> ERASE if continuous is high, else IDLE.
- Frame period in continuous mode = C_ERASE+C_EXPOSE+C_CONVERT+C_READ+4 cycles (524 by default).
- start is ignored while busy; start held high in IDLE after GAP_R begins a new frame.
- pixel_counter:
  - 0 outside CONVERT.
  - In the k-th CONVERT cycle (k from 0) it equals k.
  - Saturates at all-ones; never wraps.
  - Returns to 0 on the edge leaving CONVERT.
- Capture: on the edge ending the last READ cycle, out_data <= pix_data and out_valid <= 1 (same edge read falls).
- out_valid clears on any edge where out_valid & out_ready, unless a capture occurs on that edge; capture wins, so out_valid stays 1 with new data.
- Capture while out_valid=1 and out_ready=0: data overwritten, overrun set.
- overrun clears only on reset.
- out_data is stable while out_valid=1 and no capture occurs.
- Reset mid-phase: immediate return to IDLE, all controls low; no partial capture.

Decomposition:
- PixelSensorConfig package: add typedef enum ctrl_state_t (the nine states) and default phase-length constants C_ERASE/C_EXPOSE/C_CONVERT/C_READ alongside PIXEL_BITS.
- One sub-module, phase_timer:
  - Loadable down-counter, width $clog2(max C)+1.
  - Inputs load and len; outputs last (high in the final cycle of a phase).
  - Instantiated once; the FSM loads it on every phase entry.

Test Plan:
- Reset mid-EXPOSE (reset low at cycle 100 after start) -> all outputs 0 within same cycle, busy=0; later start -> erase after 1 cycle.
- Single frame, continuous=0, pix_data forced 8'hA5 during read:
  - erase high 5 cycles, gap, expose 255, gap, convert 255, gap, read 5, gap, IDLE.
  - out_data=8'hA5 and out_valid=1 on read fall.
- Ramp check during a single frame:
  - pixel_counter = 0,1,...,254 across CONVERT.
  - With C_CONVERT=300 it saturates at 255 from k=255.
- Continuous=1, out_ready=1, pix_data increments per frame: rising edges of erase exactly 524 cycles apart; each out_valid pulse lasts 1 cycle with the correct value; overrun stays 0.
- out_ready=0 across two frames: second capture overwrites out_data, overrun=1, out_valid stays 1; raising out_ready clears out_valid next edge, overrun remains 1.
- start pulsed during CONVERT -> ignored; no extra frame after IDLE; frame timing unchanged.
